data_mem_responder: RTL and testbench

//  Multi-cycle responder for the CPU data-memory port. Accepts one load/store request
//  at a time over a req/ack handshake, models a fixed access latency and returns read

---
 rtl/mem_resp_pkg.sv | 14 +
 rtl/mem_resp_sram.sv | 41 ++++
 rtl/data_mem_responder.sv | 135 +++++++++++++
 tb/tb_data_mem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, counter and
// byte-enable widths.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int CNT_W = 4;
   localparam int BE_W  = 4;

endpackage

// File: rtl/mem_resp_sram.sv
// DEPTH x 32 synchronous word array with per-byte write enables and a registered
// read port; the read register can be cleared to report an aborted access.
module mem_resp_sram
   import mem_resp_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            wr_en,
   input  logic [BE_W-1:0] be,
   input  logic [AW-1:0]   idx,
   input  logic [31:0]     wdata,
   input  logic            rd_en,
   input  logic            rd_clr,
   output logic [31:0]     rdata
);

   logic [31:0] mem [DEPTH];

   // Array storage is deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rdata <= '0;
      end else if (rd_clr) begin
         rdata <= '0;
      end else if (rd_en) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder for the CPU data port (req/ack, fixed latency).
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
//
// Handshake: the initiator raises req_i with we/addr/wdata/be stable and holds it
// until ack_o; the request is captured at the first IDLE edge that sees req_i=1 and
// ack_o pulses for one cycle when the access completes. req_i is ignored while busy.
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 3
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_i,
   input  logic            we_i,
   input  logic [31:0]     addr_i,
   input  logic [31:0]     wdata_i,
   input  logic [BE_W-1:0] be_i,
   output logic            ack_o,
   output logic [31:0]     rdata_o,
   output logic            busy_o,
   output logic            err_o,
   output logic [1:0]      state_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              cap_we;
   logic [AW+1:0]     cap_addr;
   logic [31:0]       cap_wdata;
   logic [BE_W-1:0]   cap_be;

   logic              acc_we;
   logic [AW+1:0]     acc_addr;
   logic [31:0]       acc_wdata;
   logic [BE_W-1:0]   acc_be;
   logic              commit;
   logic              mis;
   logic              unused_bits;

   // With LATENCY=1 the access commits on the capture edge, so use the live inputs.
   always_comb begin
      acc_we    = cap_we;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
      acc_be    = cap_be;
      if (state == ST_IDLE) begin
         acc_we    = we_i;
         acc_addr  = addr_i[AW+1:0];
         acc_wdata = wdata_i;
         acc_be    = be_i;
      end
   end

   assign commit = ((state == ST_IDLE) && req_i && (LATENCY == 1)) ||
                   ((state == ST_WAIT) && (cnt == '0));

`ifdef MEM_ALIGN_CHECK_EN
   assign mis = (acc_addr[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif

   assign unused_bits = ^{addr_i[31:AW+2], acc_addr[1:0]};

   mem_resp_sram #(.DEPTH(DEPTH), .AW(AW)) u_sram (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .wr_en  (commit && acc_we && !mis),
      .be     (acc_be),
      .idx    (acc_addr[AW+1:2]),
      .wdata  (acc_wdata),
      .rd_en  (commit && !acc_we && !mis),
      .rd_clr (commit && mis),
      .rdata  (rdata_o)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         ack_o     <= 1'b0;
         busy_o    <= 1'b0;
         err_o     <= 1'b0;
         cap_we    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_be    <= '0;
      end else begin
         ack_o <= 1'b0;
         err_o <= commit && mis;
         case (state)
            ST_IDLE: begin
               if (req_i) begin
                  cap_we    <= we_i;
                  cap_addr  <= addr_i[AW+1:0];
                  cap_wdata <= wdata_i;
                  cap_be    <= be_i;
                  busy_o    <= 1'b1;
                  if (LATENCY == 1) begin
                     state <= ST_RESP;
                     ack_o <= 1'b1;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  state <= ST_RESP;
                  ack_o <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RESP: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder (LATENCY=3 main instance plus a
// LATENCY=1 instance for the back-to-back rate check).
module tb_data_mem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 3;
   localparam int AW    = $clog2(DEPTH);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  be = '0;
   logic        ack, busy, err;
   logic [31:0] rdata;
   logic [1:0]  state;

   logic        req1 = 1'b0;
   logic        ack1, busy1, err1;
   logic [31:0] rdata1;
   logic [1:0]  state1;

   logic [31:0] model_mem [DEPTH];
   logic [31:0] last_rdata = '0;
   logic [31:0] exp_q[$];
   logic        exp_err_q[$];
   int          checks = 0;
   int          errors = 0;

   data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .be_i(be), .ack_o(ack), .rdata_o(rdata),
      .busy_o(busy), .err_o(err), .state_o(state)
   );

   data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(1'b0), .addr_i(32'h0),
      .wdata_i(32'h0), .be_i(4'h0), .ack_o(ack1), .rdata_o(rdata1),
      .busy_o(busy1), .err_o(err1), .state_o(state1)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference model: word array indexed modulo DEPTH, byte-masked stores
   task automatic predict(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b);
      int idx;
      bit misaligned;
      idx = int'(a[AW+1:2]);
`ifdef MEM_ALIGN_CHECK_EN
      misaligned = (a[1:0] != 2'b00);
`else
      misaligned = 1'b0;
`endif
      if (misaligned) begin
         last_rdata = '0;
         exp_q.push_back('0);
         exp_err_q.push_back(1'b1);
      end else begin
         if (w) begin
            for (int k = 0; k < 4; k++)
               if (b[k]) model_mem[idx][8*k +: 8] = d[8*k +: 8];
         end else begin
            last_rdata = model_mem[idx];
         end
         exp_q.push_back(last_rdata);
         exp_err_q.push_back(1'b0);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst && ack) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack with rdata %h, expected no ack", rdata);
         end else begin
            check("rdata_at_ack", rdata, exp_q.pop_front());
            check("err_at_ack", {31'b0, err}, {31'b0, exp_err_q.pop_front()});
         end
      end
   end

   // driver: one request, released after capture; ack expected LAT edges after
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b);
      int n;
      @(negedge clk);
      we = w; addr = a; wdata = d; be = b; req = 1'b1;
      predict(w, a, d, b);
      @(posedge clk);
      #1 req = 1'b0;
      we = $urandom_range(0, 1); addr = $urandom; wdata = $urandom; be = 4'($urandom);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack && n < 50);
      check("ack_latency", n, LAT);
      @(posedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ack"}, {31'b0, ack}, 32'h0);
      check({tag, "_rdata"}, rdata, 32'h0);
      check({tag, "_busy"}, {31'b0, busy}, 32'h0);
      check({tag, "_err"}, {31'b0, err}, 32'h0);
      check({tag, "_state"}, {30'b0, state}, 32'h0);
   endtask

   initial begin
      int n, lows, acks;
      logic [31:0] a;

      #1 rst = 1'b0;
      #3 check_outputs_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // fill the array so every later load has a known expected value
      for (int i = 0; i < DEPTH; i++) access(1'b1, 32'(i * 4), $urandom, 4'hF);

      // full store and load
      access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      access(1'b0, 32'h10, 32'h0, 4'h0);
      check("load_deadbeef", rdata, 32'hDEADBEEF);

      // partial byte store
      access(1'b1, 32'h10, 32'h11223344, 4'b0101);
      access(1'b0, 32'h10, 32'h0, 4'h0);
      check("load_partial", rdata, 32'hDE22BE44);

      // aliasing modulo 4*DEPTH bytes
      access(1'b1, 32'h400, 32'hCAFEF00D, 4'hF);
      access(1'b0, 32'h000, 32'h0, 4'h0);
      check("load_alias", rdata, 32'hCAFEF00D);

      // empty byte enable leaves array and read data untouched
      access(1'b1, 32'h10, 32'h55555555, 4'h0);
      check("store_holds_rdata", rdata, 32'hCAFEF00D);
      access(1'b0, 32'h10, 32'h0, 4'h0);
      check("load_after_be0", rdata, 32'hDE22BE44);

      // misaligned load
      access(1'b0, 32'h13, 32'h0, 4'h0);
`ifdef MEM_ALIGN_CHECK_EN
      check("misaligned_rdata", rdata, 32'h0);
`else
      check("misaligned_rdata", rdata, 32'hDE22BE44);
`endif

      // random traffic
      for (int i = 0; i < 200; i++)
         access(1'(($urandom_range(0, 1))), $urandom, $urandom, 4'($urandom_range(0, 15)));

      // req held high: one access per LAT+1 cycles, busy low one cycle between
      @(negedge clk);
      a = {$urandom_range(0, DEPTH - 1), 2'b00};
      we = 1'b0; addr = a; req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         predict(1'b0, a, 32'h0, 4'h0);
         n = 0;
         lows = 0;
         do begin
            @(negedge clk);
            n++;
            if (!busy) lows++;
         end while (!ack && n < 50);
         if (i == 5) req = 1'b0;
         if (i > 0) begin
            check("burst_period", n, LAT + 1);
            check("burst_busy_low", lows, 1);
         end else begin
            check("burst_first_latency", n, LAT);
         end
      end
      repeat (3) @(negedge clk);

      // LATENCY=1 instance with req held high: ack every 2 cycles
      req1 = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack1 && n < 50);
      check("lat1_first_latency", n, 1);
      for (int i = 0; i < 4; i++) begin
         n = 0;
         lows = 0;
         do begin
            @(negedge clk);
            n++;
            if (!busy1) lows++;
         end while (!ack1 && n < 50);
         check("lat1_period", n, 2);
         check("lat1_busy_low", lows, 1);
      end
      req1 = 1'b0;
      repeat (3) @(negedge clk);

      // reset during WAIT of a store aborts it
      a = 32'h20;
      @(negedge clk);
      we = 1'b1; addr = a; wdata = ~model_mem[8]; be = 4'hF; req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      check("abort_in_wait", {30'b0, state}, 32'd1);
      #2 rst = 1'b0;
      #1 check_outputs_zero("abort");
      last_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      acks = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack) acks++;
      end
      check("abort_no_ack", acks, 0);
      access(1'b0, a, 32'h0, 4'h0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
